// File: rtl/mem_data_access_pkg.sv
// Shared types for the MEM-stage data-memory access controller:
// load/store encodings, controller states and bus size codes.
package mem_data_access_pkg;

  typedef enum logic [2:0] {LB, LBU, LH, LHU, LW} LoadType_t;
  typedef enum logic [1:0] {SB, SH, SW} StoreType_t;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_CANCEL} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [1:0] accessSize(input logic isLoad, input LoadType_t lt,
                                            input StoreType_t st);
    logic [1:0] size;
    size = SIZE_WORD;
    if (isLoad) begin
      case (lt)
        LB, LBU: size = SIZE_BYTE;
        LH, LHU: size = SIZE_HALF;
        default: size = SIZE_WORD;
      endcase
    end else begin
      case (st)
        SB:      size = SIZE_BYTE;
        SH:      size = SIZE_HALF;
        default: size = SIZE_WORD;
      endcase
    end
    return size;
  endfunction

endpackage

// File: rtl/mem_data_access_load_extend.sv
// Selects the addressed byte/half lane of a raw read word and
// sign- or zero-extends it to 32 bits according to the load type.
module load_extend
  import mem_data_access_pkg::*;
(
  input  logic [1:0]  i_addrLo,
  input  LoadType_t   i_loadType,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[8*i_addrLo +: 8];
  assign w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_result = i_rdata;
    case (i_loadType)
      LB:      o_result = {{24{w_byte[7]}}, w_byte};
      LBU:     o_result = {24'd0, w_byte};
      LH:      o_result = {{16{w_half[15]}}, w_half};
      LHU:     o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_data_access.sv
// MEM-stage data-memory access controller: issues one load/store over a split
// address/data bus, stalls the pipeline until it completes, and extends loads.
module mem_data_access
  import mem_data_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_MemValid,
  input  logic        MEM_IsLoad,
  input  LoadType_t   MEM_LoadType,
  input  StoreType_t  MEM_StoreType,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_OutB,
  input  logic        MEM_Flush,
  input  logic        WB_Stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] MEM_DMOut,
  output logic        MEM_DMStall,
  output logic        MEM_AdEL,
  output logic        MEM_AdES
);

  state_t      r_state;
  logic        r_flushSeen;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  LoadType_t   r_loadType;
  logic [31:0] r_dmBuf;

  logic [1:0]  w_size;
  logic        w_misaligned;
  logic        w_start;
  logic        w_inAddr;
  logic [31:0] w_wdata;
  logic [31:0] w_ext;

  assign w_size       = accessSize(MEM_IsLoad, MEM_LoadType, MEM_StoreType);
  assign w_misaligned = ((w_size == SIZE_HALF) && MEM_ALUOut[0]) ||
                        ((w_size == SIZE_WORD) && (MEM_ALUOut[1:0] != 2'b00));
  assign MEM_AdEL     = MEM_MemValid &  MEM_IsLoad & w_misaligned;
  assign MEM_AdES     = MEM_MemValid & ~MEM_IsLoad & w_misaligned;
  assign w_start      = MEM_MemValid & ~w_misaligned & ~MEM_Flush;
  assign w_inAddr     = (r_state == S_ADDR);

  always_comb begin
    w_wdata = MEM_OutB;
    case (MEM_StoreType)
      SB:      w_wdata = {4{MEM_OutB[7:0]}};
      SH:      w_wdata = {2{MEM_OutB[15:0]}};
      default: w_wdata = MEM_OutB;
    endcase
  end

  // While waiting for addr_ok the request comes from the captured copy, so a
  // flush that changes MEM underneath cannot alter an in-flight request.
  assign data_req   = ((r_state == S_IDLE) & w_start) | w_inAddr;
  assign data_wr    = w_inAddr ? r_wr    : ~MEM_IsLoad;
  assign data_size  = w_inAddr ? r_size  : w_size;
  assign data_addr  = w_inAddr ? r_addr  : MEM_ALUOut;
  assign data_wdata = w_inAddr ? r_wdata : w_wdata;

  load_extend u_loadExtend (
    .i_addrLo   (r_addr[1:0]),
    .i_loadType (r_loadType),
    .i_rdata    (data_rdata),
    .o_result   (w_ext)
  );

  assign MEM_DMStall = ((r_state == S_IDLE) & w_start) | w_inAddr |
                       ((r_state == S_DATA) & ~data_data_ok) | (r_state == S_CANCEL);
  assign MEM_DMOut   = ((r_state == S_DATA) && data_data_ok) ? w_ext : r_dmBuf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_flushSeen <= 1'b0;
      r_wr        <= 1'b0;
      r_size      <= SIZE_BYTE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_loadType  <= LB;
      r_dmBuf     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_wr        <= ~MEM_IsLoad;
            r_size      <= w_size;
            r_addr      <= MEM_ALUOut;
            r_wdata     <= w_wdata;
            r_loadType  <= MEM_LoadType;
            r_flushSeen <= 1'b0;
            r_state     <= data_addr_ok ? S_DATA : S_ADDR;
          end
        end
        S_ADDR: begin
          if (data_addr_ok) begin
            r_state <= (r_flushSeen | MEM_Flush) ? S_CANCEL : S_DATA;
          end else if (MEM_Flush) begin
            r_flushSeen <= 1'b1;
          end
        end
        S_DATA: begin
          // A completing access beats a simultaneous flush; the flushed MEM/WB drops it.
          if (data_data_ok) begin
            if (WB_Stall && !MEM_Flush) begin
              r_dmBuf <= w_ext;
              r_state <= S_DONE;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (MEM_Flush) begin
            r_state <= S_CANCEL;
          end
        end
        S_DONE: begin
          if (!WB_Stall || MEM_Flush) r_state <= S_IDLE;
        end
        S_CANCEL: begin
          if (data_data_ok) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_data_access.md
# mem_data_access

MEM-stage data-memory access controller. Issues load/store requests for the instruction in MEM over a split address/data SRAM-like bus. Stalls the pipeline until the access completes, and delivers the byte-aligned, extended load result as MEM_DMOut to the MEM/WB pipeline register. Also flags misaligned accesses as AdEL/AdES, which are merged into the MEM exception type.

## Interface
Parameters: none. Widths are fixed at 32-bit address and data.

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset (`RstEnable` = 0)
- MEM_MemValid  in  1  instruction in MEM is a load/store with no earlier exception
- MEM_IsLoad  in  1  1 = load, 0 = store
- MEM_LoadType  in  LoadType_t  LB/LBU/LH/LHU/LW
- MEM_StoreType  in  StoreType_t  SB/SH/SW
- MEM_ALUOut  in  32  effective address
- MEM_OutB  in  32  store data (rt)
- MEM_Flush  in  1  exception/ERET flush of MEM
- WB_Stall  in  1  MEM/WB register held this cycle
- data_req  out  1  request valid
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  byte address, passed unchanged
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  raw read word
- MEM_DMOut  out  32  extended load result
- MEM_DMStall  out  1  hold IF..MEM
- MEM_AdEL, MEM_AdES  out  1  misaligned load / store

## Operation
- **Misalignment** (combinational): half access with addr[0]≠0, or word access with addr[1:0]≠0.
  - Asserts MEM_AdEL (load) or MEM_AdES (store), gated by MEM_MemValid.
  - No request is issued for a misaligned access.
- **start** = MEM_MemValid & ~misaligned & ~MEM_Flush.
- **States:** IDLE, ADDR, DATA, DONE, CANCEL.
- **IDLE**
  - data_req = start.
  - start & addr_ok → DATA.
  - start & ~addr_ok → ADDR.
  - Otherwise stay in IDLE.
- **ADDR**
  - data_req = 1 and all bus outputs held until addr_ok. A request is never withdrawn.
  - On addr_ok: → CANCEL if a flush was seen in this state or in this cycle, else → DATA.
- **DATA**
  - No data_ok: stay in DATA; MEM_Flush → CANCEL.
  - data_ok & WB_Stall: capture the extended result into dm_buf → DONE.
  - data_ok & ~WB_Stall: → IDLE; the pipeline advances on this edge.
  - data_ok wins over a simultaneous flush: → IDLE, and the result is ignored by the flushed MEM/WB.
- **DONE**
  - MEM_DMOut = dm_buf; no new request for the same instruction.
  - ~WB_Stall → IDLE.
  - MEM_Flush → IDLE.
- **CANCEL**: wait for data_ok, discard the data → IDLE.
- **MEM_DMStall** = (IDLE & start) | ADDR | (DATA & ~data_ok) | CANCEL.
- **MEM_DMOut**: extend(data_rdata) in the DATA cycle with data_ok; dm_buf otherwise.
- **Load extend**, lane selected by addr[1:0]:
  - LB: sign-extend the selected byte; LBU: zero-extend it.
  - LH/LHU: lane addr[1]; sign- / zero-extend respectively.
  - LW: pass-through.
- **Store data**:
  - SB: {4{OutB[7:0]}}.
  - SH: {2{OutB[15:0]}}.
  - SW: OutB.
  - data_size follows the access type.

## Timing
- **Reset values:** state IDLE, dm_buf 0, data_req 0, MEM_DMStall 0, MEM_DMOut 0, AdEL/AdES 0.
- **Reset mid-access:** → IDLE immediately; no completion is awaited (the bus shares rst).
- **Minimum load latency:** addr_ok in cycle T (same cycle as start) and data_ok at T+1. MEM_DMStall is high in T and low in T+1, and MEM/WB captures MEM_DMOut at the end of T+1.
- **Handshakes:** at most one outstanding request. addr_ok is sampled only while data_req = 1; data_ok only in DATA/CANCEL.
- **No combinational path** from data_rdata to MEM_DMStall.

## Structure
- LoadType_t, StoreType_t, the state enum and the size codes go in CPU_Defines.svh.
- Sub-module `load_extend`: combinational lane select and sign/zero extend (addr[1:0], LoadType, rdata → 32-bit result).

## Test plan
- **Aligned load hit:** LW at 0x80000004, addr_ok with req, data_ok next cycle, rdata 0xDEADBEEF → DMOut 0xDEADBEEF, stall for exactly 1 cycle.
- **LB sign-extend:** addr 0x...03, rdata 0x80112233 → 0xFFFFFF80. LHU at 0x...02, rdata 0x8001xxxx → 0x00008001.
- **SB with addr_ok delayed 3 cycles:** OutB 0x12345678 → wdata 0x78787878, size 0, req held steady for 3 cycles, stall until data_ok.
- **Misaligned LW at 0x...02:** AdEL = 1, data_req never asserted, MEM_DMStall = 0.
- **Flush while in ADDR:** req held until addr_ok → CANCEL. The later data_ok is discarded → IDLE, and no stale DMOut reaches WB.
- **data_ok while WB_Stall = 1 for 2 cycles:** DONE holds DMOut, no second request; → IDLE when WB_Stall falls.
